// File: rtl/tf_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tf_loop_sequencer
//
// Walks the (p, k) stage/group loop of a 1024-point NTT/INTT and drives the
// indices to the twiddle address generator. One start request produces a
// full sweep of 319 pairs. Each pair is held for CYC_PER_K enabled cycles.
//
// Stage order:
//   NTT  : p = 9, 8, ..., 0
//   INTT : p = 0, 1, ..., 9
// Within a stage, k counts 0 .. G(p)-1, where G(p) = min(2^(9-p), 64).
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   start       in   1  single-cycle sweep request, only accepted in IDLE
//   conf        in   3  mode, sampled on an accepted start
//                       (3'b001 or 3'b100 = NTT, anything else = INTT)
//   hold        in   1  stall; freezes all state
//   k           out  6  group index
//   p           out  4  stage index
//   conf_out    out  3  conf latched at start, constant for the sweep
//   valid       out  1  k/p/conf_out are meaningful this cycle
//   busy        out  1  a sweep is in progress
//   stage_done  out  1  pulse on the last held cycle of each stage
//   done        out  1  pulse on the cycle after the final pair
//
// Parameter:
//   CYC_PER_K   enabled cycles per (p,k) pair, legal range 1..16
// ---------------------------------------------------------------------------
module tf_loop_sequencer #(
    parameter int CYC_PER_K = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] conf,
    input  logic       hold,
    output logic [5:0] k,
    output logic [3:0] p,
    output logic [2:0] conf_out,
    output logic       valid,
    output logic       busy,
    output logic       stage_done,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(CYC_PER_K - 1);
    localparam logic [3:0] P_LAST   = 4'd9;

    // Last group index of a stage: G(p)-1 with G(p) = min(2^(9-p), 64).
    function automatic logic [5:0] last_k_of(input logic [3:0] stage);
        logic [5:0] lk;
        case (stage)
            4'd9:    lk = 6'd0;
            4'd8:    lk = 6'd1;
            4'd7:    lk = 6'd3;
            4'd6:    lk = 6'd7;
            4'd5:    lk = 6'd15;
            4'd4:    lk = 6'd31;
            default: lk = 6'd63;
        endcase
        return lk;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t     state_q,      state_d;
    logic       is_ntt_q,     is_ntt_d;
    logic [3:0] cnt_q,        cnt_d;
    logic [5:0] k_q,          k_d;
    logic [3:0] p_q,          p_d;
    logic [2:0] conf_q,       conf_d;
    logic       valid_q,      valid_d;
    logic       busy_q,       busy_d;
    logic       stage_done_q, stage_done_d;
    logic       done_q,       done_d;

    logic       conf_is_ntt;
    logic       last_k_hit;
    logic       last_cnt_hit;
    logic       final_stage;

    assign conf_is_ntt  = (conf == 3'b001) || (conf == 3'b100);
    assign last_k_hit   = (k_q == last_k_of(p_q));
    assign last_cnt_hit = (cnt_q == CNT_LAST);
    assign final_stage  = is_ntt_q ? (p_q == 4'd0) : (p_q == P_LAST);

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        is_ntt_d = is_ntt_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        p_d      = p_q;
        conf_d   = conf_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    is_ntt_d = conf_is_ntt;
                    conf_d   = conf;
                    p_d      = conf_is_ntt ? P_LAST : 4'd0;
                    k_d      = 6'd0;
                    cnt_d    = 4'd0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            RUN: begin
                if (!last_cnt_hit) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd0;
                    if (!last_k_hit) begin
                        k_d = k_q + 6'd1;
                    end else if (final_stage) begin
                        // No wrap past the last stage: the sweep ends here.
                        state_d = FINISH;
                        k_d     = 6'd0;
                        p_d     = 4'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = 6'd0;
                        p_d = is_ntt_q ? (p_q - 4'd1) : (p_q + 4'd1);
                    end
                end
            end

            FINISH: begin
                // start is deliberately not looked at here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // stage_done is registered alongside the pair it describes, so it is
        // computed from the next pair rather than the current one.
        stage_done_d = (state_d == RUN) && (cnt_d == CNT_LAST) &&
                       (k_d == last_k_of(p_d));
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge next value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_ntt_q     <= 1'b0;
            cnt_q        <= 4'd0;
            k_q          <= 6'd0;
            p_q          <= 4'd0;
            conf_q       <= 3'd0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else if (!hold) begin
            state_q      <= state_d;
            is_ntt_q     <= is_ntt_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            p_q          <= p_d;
            conf_q       <= conf_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            stage_done_q <= stage_done_d;
            done_q       <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign k        = k_q;
    assign p        = p_q;
    assign conf_out = conf_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

    // The pulse flops are frozen during a stall, so a pulse that lands on a
    // held cycle is masked here and shows up again on the first released one.
    assign stage_done = stage_done_q & ~hold;
    assign done       = done_q & ~hold;

endmodule

// File: tb/tb_tf_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tf_loop_sequencer
//
// Two instances share their inputs: one with CYC_PER_K=1, one with
// CYC_PER_K=4. sel4 picks which instance is being observed. Expected pairs
// are pushed to a scoreboard queue when a sweep is started and popped as
// the observed instance presents valid cycles.
// ---------------------------------------------------------------------------
module tb_tf_loop_sequencer;

    localparam int N_PAIRS = 319;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic [2:0] conf  = 3'd0;

    logic [5:0] k1, k4;
    logic [3:0] p1, p4;
    logic [2:0] co1, co4;
    logic       v1, v4, b1, b4, sd1, sd4, d1, d4;

    tf_loop_sequencer #(.CYC_PER_K(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .conf(conf), .hold(hold),
        .k(k1), .p(p1), .conf_out(co1), .valid(v1), .busy(b1),
        .stage_done(sd1), .done(d1)
    );

    tf_loop_sequencer #(.CYC_PER_K(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .conf(conf), .hold(hold),
        .k(k4), .p(p4), .conf_out(co4), .valid(v4), .busy(b4),
        .stage_done(sd4), .done(d4)
    );

    bit sel4 = 1'b0;

    logic [5:0] o_k;
    logic [3:0] o_p;
    logic [2:0] o_conf;
    logic       o_valid, o_busy, o_sd, o_done;

    assign o_k     = sel4 ? k4  : k1;
    assign o_p     = sel4 ? p4  : p1;
    assign o_conf  = sel4 ? co4 : co1;
    assign o_valid = sel4 ? v4  : v1;
    assign o_busy  = sel4 ? b4  : b1;
    assign o_sd    = sel4 ? sd4 : sd1;
    assign o_done  = sel4 ? d4  : d1;

    typedef struct packed {
        logic [3:0] p;
        logic [5:0] k;
        logic       sd;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Per-sweep statistics gathered by run_sweep.
    int n_valid, n_held, n_sd, done_cyc, sd_p8_idx;
    int first_p, first_k, v2_p, v2_k, v3_p, v3_k, last_p, last_k;
    bit done_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference pair sequence, built from the stage order and G(p) table.
    function automatic void build_expected(input bit ntt, input int cyc);
        sb.delete();
        for (int s = 0; s < 10; s++) begin
            int pp;
            int g;
            pp = ntt ? (9 - s) : s;
            g  = (pp <= 3) ? 64 : (1 << (9 - pp));
            for (int kk = 0; kk < g; kk++) begin
                for (int c = 0; c < cyc; c++) begin
                    exp_t e;
                    e.p  = 4'(pp);
                    e.k  = 6'(kk);
                    e.sd = (kk == g - 1) && (c == cyc - 1);
                    sb.push_back(e);
                end
            end
        end
    endfunction

    // One clock: inputs change just after the rising edge, outputs are
    // sampled on the following falling edge.
    task automatic step(input logic st, input logic [2:0] cf, input logic hd, input logic rs);
        @(posedge clk);
        #1;
        start = st;
        conf  = cf;
        hold  = hd;
        rst   = rs;
        @(negedge clk);
    endtask

    task automatic reset_all();
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
    endtask

    // Runs one sweep on the observed instance. Cycle 0 carries start; cycle
    // n (n >= 1) is the n-th cycle after start was sampled.
    task automatic run_sweep(input logic [2:0] cf, input bit ntt, input int cyc,
                             input int hold_cyc, input int hold_len,
                             input int rst_cyc, input int spam_cyc,
                             input bit start_on_done);
        int         budget;
        int         expect_done;
        bit         stop_loop;
        logic [2:0] cf2;
        exp_t       e;

        budget      = N_PAIRS * cyc + hold_len + 20;
        expect_done = N_PAIRS * cyc + hold_len + 1;
        cf2         = ntt ? 3'b010 : 3'b001;  // opposite mode, must be ignored
        stop_loop   = 1'b0;
        n_valid = 0; n_held = 0; n_sd = 0; done_cyc = 0; sd_p8_idx = 0;
        first_p = -1; first_k = -1; v2_p = -1; v2_k = -1; v3_p = -1; v3_k = -1;
        last_p = -1; last_k = -1; done_flag = 1'b0;

        build_expected(ntt, cyc);

        step(1'b1, cf, 1'b0, 1'b0);
        chk("start_cycle_valid", 32'(o_valid), 32'd0);

        for (int n = 1; n <= budget && !stop_loop; n++) begin
            logic st, hd, rs;
            st = 1'b0;
            hd = (n >= hold_cyc) && (n < hold_cyc + hold_len);
            rs = (rst_cyc > 0) && (n == rst_cyc || n == rst_cyc + 1);
            if (n == spam_cyc) st = 1'b1;
            if (start_on_done && n == expect_done) st = 1'b1;
            step(st, cf2, hd, rs);

            if (rst_cyc > 0 && n > rst_cyc) begin
                chk("rst_valid", 32'(o_valid), 32'd0);
                chk("rst_busy",  32'(o_busy),  32'd0);
                chk("rst_done",  32'(o_done),  32'd0);
                chk("rst_sd",    32'(o_sd),    32'd0);
                chk("rst_k",     32'(o_k),     32'd0);
                chk("rst_p",     32'(o_p),     32'd0);
                chk("rst_conf",  32'(o_conf),  32'd0);
                if (n == rst_cyc + 2) stop_loop = 1'b1;
            end else if (o_done) begin
                done_flag = 1'b1;
                done_cyc  = n;
                stop_loop = 1'b1;
                chk("done_valid", 32'(o_valid), 32'd0);
                chk("done_busy",  32'(o_busy),  32'd0);
                chk("done_sb_empty", 32'(sb.size()), 32'd0);
            end else if (o_valid) begin
                chk("run_busy", 32'(o_busy), 32'd1);
                chk("run_conf", 32'(o_conf), 32'(cf));
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else if (hd) begin
                    e = sb[0];
                    n_held++;
                    chk("hold_p",  32'(o_p),  32'(e.p));
                    chk("hold_k",  32'(o_k),  32'(e.k));
                    chk("hold_sd", 32'(o_sd), 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_valid++;
                    chk("pair_p",  32'(o_p),  32'(e.p));
                    chk("pair_k",  32'(o_k),  32'(e.k));
                    chk("pair_sd", 32'(o_sd), 32'(e.sd));
                    if (n_valid == 1) begin first_p = int'(o_p); first_k = int'(o_k); end
                    if (n_valid == 2) begin v2_p = int'(o_p); v2_k = int'(o_k); end
                    if (n_valid == 3) begin v3_p = int'(o_p); v3_k = int'(o_k); end
                    last_p = int'(o_p);
                    last_k = int'(o_k);
                    if (o_sd) begin
                        n_sd++;
                        if (o_p == 4'd8) sd_p8_idx = n_valid;
                    end
                end
            end else begin
                chk("run_valid_gap", 32'(o_valid), 32'd1);
                stop_loop = 1'b1;
            end
        end

        if (rst_cyc == 0) begin
            if (!done_flag) chk("done_timeout", 32'd0, 32'd1);
            for (int i = 0; i < 3; i++) begin
                step(1'b0, cf2, 1'b0, 1'b0);
                check_idle("post");
            end
        end
    endtask

    initial begin
        // Reset state, both instances.
        step(1'b1, 3'b001, 1'b1, 1'b1);
        step(1'b1, 3'b001, 1'b0, 1'b1);
        chk("reset_k1", 32'(k1), 32'd0);
        chk("reset_p1", 32'(p1), 32'd0);
        chk("reset_conf1", 32'(co1), 32'd0);
        chk("reset_vbsd1", 32'({v1, b1, sd1, d1}), 32'd0);
        chk("reset_k4", 32'(k4), 32'd0);
        chk("reset_vbsd4", 32'({v4, b4, sd4, d4}), 32'd0);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        check_idle("idle");

        // start with hold=1 in IDLE is not accepted.
        step(1'b1, 3'b001, 1'b1, 1'b0);
        step(1'b0, 3'b001, 1'b0, 1'b0);
        check_idle("held_start");

        // NTT, one cycle per pair.
        sel4 = 1'b0;
        reset_all();
        run_sweep(3'b001, 1'b1, 1, 0, 0, 0, 0, 1'b0);
        chk("ntt1_n_valid", 32'(n_valid), 32'd319);
        chk("ntt1_first_p", 32'(first_p), 32'd9);
        chk("ntt1_first_k", 32'(first_k), 32'd0);
        chk("ntt1_v2", 32'({v2_p[7:0], v2_k[7:0]}), 32'({8'd8, 8'd0}));
        chk("ntt1_v3", 32'({v3_p[7:0], v3_k[7:0]}), 32'({8'd8, 8'd1}));
        chk("ntt1_last", 32'({last_p[7:0], last_k[7:0]}), 32'({8'd0, 8'd63}));
        chk("ntt1_n_sd", 32'(n_sd), 32'd10);
        chk("ntt1_done_cyc", 32'(done_cyc), 32'd320);

        // INTT, one cycle per pair.
        reset_all();
        run_sweep(3'b010, 1'b0, 1, 0, 0, 0, 0, 1'b0);
        chk("intt1_n_valid", 32'(n_valid), 32'd319);
        chk("intt1_first", 32'({first_p[7:0], first_k[7:0]}), 32'({8'd0, 8'd0}));
        chk("intt1_last", 32'({last_p[7:0], last_k[7:0]}), 32'({8'd9, 8'd0}));
        chk("intt1_n_sd", 32'(n_sd), 32'd10);
        chk("intt1_done_cyc", 32'(done_cyc), 32'd320);

        // NTT via conf=100, four cycles per pair.
        sel4 = 1'b1;
        reset_all();
        run_sweep(3'b100, 1'b1, 4, 0, 0, 0, 0, 1'b0);
        chk("ntt4_n_valid", 32'(n_valid), 32'd1276);
        chk("ntt4_sd_p8_idx", 32'(sd_p8_idx), 32'd12);
        chk("ntt4_n_sd", 32'(n_sd), 32'd10);
        chk("ntt4_done_cyc", 32'(done_cyc), 32'd1277);

        // Five-cycle stall while (p=6,k=3) is presented (cycle 11 after start).
        sel4 = 1'b0;
        reset_all();
        run_sweep(3'b001, 1'b1, 1, 11, 5, 0, 0, 1'b0);
        chk("hold_n_valid", 32'(n_valid), 32'd319);
        chk("hold_n_held", 32'(n_held), 32'd5);
        chk("hold_done_cyc", 32'(done_cyc), 32'd325);

        // Reset at valid cycle 100 aborts the sweep without done.
        reset_all();
        run_sweep(3'b001, 1'b1, 1, 0, 0, 100, 0, 1'b0);
        chk("abort_no_done", 32'(done_flag), 32'd0);
        chk("abort_reached", 32'(n_valid), 32'd100);
        step(1'b0, 3'b001, 1'b0, 1'b0);
        check_idle("abort_idle");
        run_sweep(3'b001, 1'b1, 1, 0, 0, 0, 0, 1'b0);
        chk("restart_first", 32'({first_p[7:0], first_k[7:0]}), 32'({8'd9, 8'd0}));
        chk("restart_n_valid", 32'(n_valid), 32'd319);
        chk("restart_done_cyc", 32'(done_cyc), 32'd320);

        // start while busy and on the done cycle: both ignored.
        reset_all();
        run_sweep(3'b010, 1'b0, 1, 0, 0, 0, 50, 1'b1);
        chk("spam_n_valid", 32'(n_valid), 32'd319);
        chk("spam_done_cyc", 32'(done_cyc), 32'd320);

        // After the ignored done-cycle start, a start in IDLE is accepted.
        run_sweep(3'b100, 1'b1, 1, 0, 0, 0, 0, 1'b0);
        chk("after_done_first_p", 32'(first_p), 32'd9);
        chk("after_done_n_valid", 32'(n_valid), 32'd319);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tf_loop_sequencer.md
TF_LOOP_SEQUENCER -- requirements
Module: tf_loop_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk (rising edge), rst.
REQ-002 Parameter CYC_PER_K, default 4, SHALL set the number of enabled cycles each (p,k) pair is held; legal range 1..16.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle request to begin one full transform sweep.
REQ-006 conf  input  3  transform mode, sampled on accepted start; 3'b001 or 3'b100 = NTT, any other value = INTT.
REQ-007 hold  input  1  stall; when 1, all state and outputs freeze.
REQ-008 k  output  6  group index driven to the twiddle address generator.
REQ-009 p  output  4  stage index driven to the twiddle address generator.
REQ-010 conf_out  output  3  latched conf, constant for the whole sweep.
REQ-011 valid  output  1  k/p/conf_out are meaningful this cycle.
REQ-012 busy  output  1  sweep in progress (start accepted, done not yet pulsed).
REQ-013 stage_done  output  1  one-cycle pulse on the last held cycle of each stage.
REQ-014 done  output  1  one-cycle pulse on the first cycle after the final pair's last held cycle.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FINISH; all outputs SHALL be registered.
REQ-016 IDLE->RUN on start=1 with hold=0; start SHALL be ignored in RUN and FINISH.
REQ-017 On entering RUN, the first pair SHALL appear with valid=1 on the cycle after start is sampled.
REQ-018 NTT stage order SHALL be p = 9,8,...,0; INTT stage order SHALL be p = 0,1,...,9.
REQ-019 Within every stage, k SHALL count 0 up to G(p)-1, where G(p) = min(2^(9-p), 64), giving G = 1,2,4,8,16,32,64,64,64,64 for p = 9..0.
REQ-020 Each pair SHALL be held for exactly CYC_PER_K non-held cycles; an internal cycle counter SHALL run 0..CYC_PER_K-1 and wrap.
REQ-021 A full sweep SHALL contain 319 pairs, i.e. 319*CYC_PER_K valid cycles, excluding hold cycles.
REQ-022 stage_done SHALL assert on the cycle whose output is k=G(p)-1 with counter=CYC_PER_K-1; it is not suppressed on the final stage.
REQ-023 After the final pair, the FSM SHALL go to FINISH for one cycle with valid=0, busy=0 and done=1, then return to IDLE.
REQ-024 hold=1 SHALL freeze the counter, k, p, valid, busy and FSM state; stage_done and done SHALL read 0 during hold and SHALL re-assert on the first non-held cycle.
REQ-025 k SHALL never exceed 63 and p SHALL never exceed 9; there SHALL be no wrap beyond the last stage.
REQ-026 start coinciding with done (FINISH) SHALL be ignored; start on the following IDLE cycle SHALL be accepted.
REQ-027 conf SHALL NOT affect an in-progress sweep.

Reset
REQ-028 While rst=1, the module SHALL force IDLE, k=0, p=0, conf_out=0, valid=0, busy=0, stage_done=0, done=0, and counter=0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep without a done pulse; a new start SHALL be accepted on the first cycle after rst deasserts.
REQ-030 rst SHALL take priority over start and hold.

Verification
REQ-031 CYC_PER_K=1, conf=001, start -> 319 consecutive valid cycles; first (p=9,k=0), then (8,0),(8,1); last (0,63); 10 stage_done pulses; done on cycle 320.
REQ-032 CYC_PER_K=1, conf=010 (INTT) -> first pair (p=0,k=0), last pair (p=9,k=0); order p ascending; 319 valid cycles.
REQ-033 CYC_PER_K=4, conf=100 -> each pair is held 4 cycles; total 1276 valid cycles; the stage_done pulse for p=8 is on valid cycle 12.
REQ-034 hold=1 for 5 cycles during (p=6,k=3) -> outputs frozen; sweep length is extended by exactly 5 cycles; pair sequence is unchanged.
REQ-035 rst asserted at valid cycle 100, then start 2 cycles after release -> no done pulse for the aborted sweep; the new sweep restarts at its first pair.
REQ-036 start pulsed while busy and again on the done cycle -> both ignored; exactly one sweep runs.
